// File: rtl/vga_text_renderer.sv
// 640x480@60 Hz VGA text-mode renderer: 80x30 cells of 8x16 glyphs, 3-stage read pipeline.
// Optional blinking underline cursor when VGA_CURSOR_EN is defined.
module vga_text_renderer #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] addr_read,
  input  logic [7:0]  data_read,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        pixel,
  output logic        active,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
`ifdef VGA_CURSOR_EN
  ,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_count;
  logic [9:0] v_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
    end else begin
      h_count <= h_count + 10'd1;
    end
  end

  // Stage 0 decode of the current raster point.
  logic [6:0]  col;
  logic [4:0]  row;
  logic [3:0]  glyph_line;
  logic [2:0]  bit_idx;
  logic [11:0] cell_addr;
  logic        active_raw;
  logic        in_hsync_raw;
  logic        in_vsync_raw;
  logic        frame_start_raw;
  logic        cursor_raw;

  assign col             = h_count[9:3];
  assign row             = v_count[8:4];
  assign glyph_line      = v_count[3:0];
  assign bit_idx         = h_count[2:0];
  assign cell_addr       = 12'({row, 6'b0}) + 12'({row, 4'b0}) + 12'(col);
  assign active_raw      = (h_count < H_VIS) && (v_count < V_VIS);
  assign in_hsync_raw    = (h_count >= HS_START) && (h_count < HS_END);
  assign in_vsync_raw    = (v_count >= VS_START) && (v_count < VS_END);
  assign frame_start_raw = (h_count == '0) && (v_count == '0);

`ifdef VGA_CURSOR_EN
  // Counts completed frames; bit 4 gives a 32-frame blink period.
  logic [4:0] frame_counter;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_counter <= '0;
    end else if ((h_count == H_LAST) && (v_count == V_LAST)) begin
      frame_counter <= frame_counter + 5'd1;
    end
  end

  assign cursor_raw = frame_counter[4] && active_raw && (row == cursor_row) &&
                      (col == cursor_col) && (glyph_line >= 4'd14);
`else
  assign cursor_raw = 1'b0;
`endif

  // Sideband delay lines; sync is carried active-high so an all-zero reset means "not in sync".
  logic [3:0] glyph_line_d1;
  logic [2:0] bit_idx_d1, bit_idx_d2;
  logic       active_d1, active_d2;
  logic       hs_d1, hs_d2;
  logic       vs_d1, vs_d2;
  logic       fs_d1, fs_d2;
  logic       cursor_d1, cursor_d2;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_read     <= '0;
      glyph_line_d1 <= '0;
      bit_idx_d1    <= '0;
      active_d1     <= 1'b0;
      hs_d1         <= 1'b0;
      vs_d1         <= 1'b0;
      fs_d1         <= 1'b0;
      cursor_d1     <= 1'b0;
      font_addr     <= '0;
      bit_idx_d2    <= '0;
      active_d2     <= 1'b0;
      hs_d2         <= 1'b0;
      vs_d2         <= 1'b0;
      fs_d2         <= 1'b0;
      cursor_d2     <= 1'b0;
      pixel         <= 1'b0;
      active        <= 1'b0;
      hsync         <= 1'b1;
      vsync         <= 1'b1;
      frame_start   <= 1'b0;
    end else begin
      // Stage 0: character address, zero outside the visible area.
      addr_read     <= active_raw ? cell_addr : 12'd0;
      glyph_line_d1 <= glyph_line;
      bit_idx_d1    <= bit_idx;
      active_d1     <= active_raw;
      hs_d1         <= in_hsync_raw;
      vs_d1         <= in_vsync_raw;
      fs_d1         <= frame_start_raw;
      cursor_d1     <= cursor_raw;
      // Stage 1: glyph row lookup.
      font_addr     <= {data_read, glyph_line_d1};
      bit_idx_d2    <= bit_idx_d1;
      active_d2     <= active_d1;
      hs_d2         <= hs_d1;
      vs_d2         <= vs_d1;
      fs_d2         <= fs_d1;
      cursor_d2     <= cursor_d1;
      // Stage 2: serialize, MSB is the leftmost pixel.
      pixel         <= (font_data[3'd7 - bit_idx_d2] & active_d2) | cursor_d2;
      active        <= active_d2;
      hsync         <= ~hs_d2;
      vsync         <= ~vs_d2;
      frame_start   <= fs_d2;
    end
  end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Randomized-memory bench for vga_text_renderer with a raster-arithmetic reference model.
// Vertical timing is shortened so whole frames fit in a short run.
module tb_vga_text_renderer;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 32;
  localparam int V_FRONT   = 1;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 1;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int FRAME     = H_TOTAL * V_TOTAL;
  localparam int VS_EXP    = (V_VISIBLE + V_FRONT) * H_TOTAL + 3;
  localparam int MID_RESET = FRAME + 10 * H_TOTAL + 700;

  logic        clk;
  logic        reset;
  logic [11:0] addr_read;
  logic [7:0]  data_read;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        pixel, active, hsync, vsync, frame_start;
`ifdef VGA_CURSOR_EN
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
`endif

  logic [7:0] mem [0:4095];
  logic [7:0] rom [0:4095];

  assign data_read = mem[addr_read];
  assign font_data = rom[font_addr];

  vga_text_renderer #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .addr_read(addr_read),
    .data_read(data_read),
    .font_addr(font_addr),
    .font_data(font_data),
    .pixel(pixel),
    .active(active),
    .hsync(hsync),
    .vsync(vsync),
    .frame_start(frame_start)
`ifdef VGA_CURSOR_EN
    ,
    .cursor_col(cursor_col),
    .cursor_row(cursor_row)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic rst_seen = 1'b1;
  int phase    = 0;

  // Cycle index counts from the first cycle with reset low (counter at 0,0).
  always @(posedge clk) begin
    cyc      <= reset ? 0 : cyc + 1;
    rst_seen <= reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int h_of(input int c);
    return c % H_TOTAL;
  endfunction

  function automatic int v_of(input int c);
    return (c / H_TOTAL) % V_TOTAL;
  endfunction

  function automatic bit vis(input int c);
    return (h_of(c) < H_VISIBLE) && (v_of(c) < V_VISIBLE);
  endfunction

  function automatic int cell_of(input int c);
    return vis(c) ? (v_of(c) / 16) * 80 + h_of(c) / 8 : 0;
  endfunction

  function automatic logic [11:0] glyph_addr(input int c);
    logic [7:0] ch;
    ch = mem[cell_of(c)];
    return {ch, 4'(v_of(c) % 16)};
  endfunction

  function automatic bit model_pixel(input int p);
    logic [7:0] g;
    bit px;
    g  = rom[glyph_addr(p)];
    px = vis(p) ? g[7 - (h_of(p) % 8)] : 1'b0;
`ifdef VGA_CURSOR_EN
    if (((p / FRAME) % 32) >= 16 && vis(p) && v_of(p) / 16 == 1 && h_of(p) / 8 == 2 &&
        v_of(p) % 16 >= 14)
      px = 1'b1;
`endif
    return px;
  endfunction

  int hs_cnt   = 0;
  int act_cnt  = 0;
  int first_hs = -1;
  int first_vs = -1;
  int fs_q[$];

  always @(negedge clk) begin
    if (rst_seen) begin
      check("rst_pixel", pixel, 1'b0);
      check("rst_active", active, 1'b0);
      check("rst_frame_start", frame_start, 1'b0);
      check("rst_addr_read", addr_read, 12'd0);
      check("rst_font_addr", font_addr, 12'd0);
      check("rst_hsync", hsync, 1'b1);
      check("rst_vsync", vsync, 1'b1);
    end else if (phase != 0) begin
      check("addr_read", addr_read, (cyc >= 1) ? 12'(cell_of(cyc - 1)) : 12'd0);
      if (cyc >= 2) check("font_addr", font_addr, glyph_addr(cyc - 2));
      if (cyc < 3) begin
        check("pixel", pixel, 1'b0);
        check("active", active, 1'b0);
        check("hsync", hsync, 1'b1);
        check("vsync", vsync, 1'b1);
        check("frame_start", frame_start, 1'b0);
      end else begin
        check("pixel", pixel, model_pixel(cyc - 3));
        check("active", active, vis(cyc - 3));
        check("hsync", hsync, !(h_of(cyc - 3) >= 656 && h_of(cyc - 3) <= 751));
        check("vsync", vsync, !(v_of(cyc - 3) >= V_VISIBLE + V_FRONT &&
                                v_of(cyc - 3) <  V_VISIBLE + V_FRONT + V_SYNC));
        check("frame_start", frame_start, (h_of(cyc - 3) == 0) && (v_of(cyc - 3) == 0));
      end

      if (phase == 1) begin
        if (cyc >= 3 && cyc < 643)
          check("line0_pattern", pixel, ((cyc - 3) % 8 == 0) || ((cyc - 3) % 8 == 7));
        if (cyc >= 3 && cyc < 803) begin
          if (!hsync) begin
            hs_cnt++;
            if (first_hs < 0) first_hs = cyc;
          end
          if (active) act_cnt++;
        end
        if (cyc == 803) begin
          check("hsync_first_low", first_hs, 659);
          check("hsync_width", hs_cnt, 96);
          check("active_per_line", act_cnt, 640);
        end
        if (frame_start) fs_q.push_back(cyc);
        if (cyc == FRAME + 4) begin
          check("frame_start_count", fs_q.size(), 2);
          if (fs_q.size() >= 2) begin
            check("frame_start_first", fs_q[0], 3);
            check("frame_start_second", fs_q[1], FRAME + 3);
          end
        end
        if (cyc == 16 * H_TOTAL + 8 + 1)   check("addr_h8_v16", addr_read, 12'd81);
        if (cyc == 31 * H_TOTAL + 639 + 1) check("addr_last_cell", addr_read, 12'd159);
        if (cyc == 31 * H_TOTAL + 640 + 1) check("addr_blank", addr_read, 12'd0);
      end else begin
        if (!vsync && first_vs < 0) first_vs = cyc;
        if (cyc == VS_EXP + 2) check("vsync_after_reset", first_vs, VS_EXP);
      end
    end
  end

  initial begin
    reset = 1'b1;
`ifdef VGA_CURSOR_EN
    cursor_col = 7'd2;
    cursor_row = 5'd1;
`endif
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 8'($urandom);
      rom[i] = 8'($urandom);
    end
    for (int i = 0; i < 80; i++) mem[i] = 8'h41;
    rom[12'h410] = 8'h81;

    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    phase = 1;

    repeat (MID_RESET) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    phase = 2;

    repeat (VS_EXP + 5) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
